// File: rtl/obstacle_if.sv
// Obstacle manager bus: game controls in, obstacle slot state out.
// master drives the controls, slave is the obstacle manager.
interface obstacle_if #(
    parameter int N_SLOTS = 4,
    parameter int X_W     = 10
);
    logic                     frame_tick;
    logic                     start;
    logic                     halt;
    logic [3:0]               speed;
    logic                     collision;
    logic [N_SLOTS*X_W-1:0]   obs_x;
    logic [N_SLOTS-1:0]       obs_type;
    logic [N_SLOTS-1:0]       obs_valid;
    logic                     game_over;
    logic                     running;
    logic [15:0]              score;

    modport master (
        output frame_tick, start, halt, speed, collision,
        input  obs_x, obs_type, obs_valid, game_over, running, score
    );

    modport slave (
        input  frame_tick, start, halt, speed, collision,
        output obs_x, obs_type, obs_valid, game_over, running, score
    );
endinterface

// File: rtl/obstacle_manager.sv
// Obstacle slot manager: scrolls, expires and spawns obstacles,
// tracks score and the IDLE/RUN/OVER game state.
module obstacle_manager #(
    parameter int          N_SLOTS   = 4,
    parameter int          X_W       = 10,
    parameter int          SCREEN_W  = 640,
    parameter int          MIN_GAP   = 160,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic       clk,
    input logic       rst_n,
    obstacle_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    localparam int             GW      = X_W + 1;
    localparam logic [X_W-1:0] SPAWN_X = X_W'(SCREEN_W - 1);

    state_t state_q, state_d;

    logic [N_SLOTS-1:0][X_W-1:0] x_q, x_d;
    logic [N_SLOTS-1:0]          t_q, t_d;
    logic [N_SLOTS-1:0]          v_q, v_d;
    logic [15:0]                 score_q, score_d;
    logic [GW-1:0]               gap_q, gap_d;
    logic [15:0]                 lfsr_q;
    logic                        run_q, over_q;

    logic          advance, restart, found;
    logic [3:0]    freed;
    logic [GW:0]   gap_sum;
    logic [GW-1:0] gap_sat;
    logic [16:0]   score_sum;
    logic [31:0]   thr;
    logic          lfsr_fb;

    assign advance = (state_q == RUN) && bus.frame_tick
                     && !bus.halt && !bus.collision;
    assign restart = (state_q != RUN) && bus.start;
    assign thr     = 32'(MIN_GAP) + {24'b0, lfsr_q[5:0], 2'b00};
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // next game state: start is only honoured outside RUN
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (bus.collision) state_d = OVER;
            OVER:    if (bus.start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // slot motion, expiry scoring and single lowest-free-slot spawn
    always_comb begin
        x_d       = x_q;
        t_d       = t_q;
        v_d       = v_q;
        score_d   = score_q;
        gap_d     = gap_q;
        freed     = '0;
        found     = 1'b0;
        score_sum = '0;
        gap_sum   = {1'b0, gap_q} + (GW+1)'(bus.speed);
        gap_sat   = gap_sum[GW] ? '1 : gap_sum[GW-1:0];
        if (restart) begin
            x_d     = '0;
            t_d     = '0;
            v_d     = '0;
            score_d = '0;
            gap_d   = '0;
        end else if (advance) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                if (v_q[i]) begin
                    if (x_q[i] >= X_W'(bus.speed)) begin
                        x_d[i] = x_q[i] - X_W'(bus.speed);
                    end else begin
                        x_d[i] = '0;
                        v_d[i] = 1'b0;
                        freed  = freed + 4'd1;
                    end
                end
            end
            score_sum = {1'b0, score_q} + {13'b0, freed};
            score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
            gap_d     = gap_sat;
            if (32'(gap_sat) >= thr) begin
                for (int i = 0; i < N_SLOTS; i++) begin
                    if (!found && !v_d[i]) begin
                        x_d[i] = SPAWN_X;
                        t_d[i] = lfsr_q[0];
                        v_d[i] = 1'b1;
                        found  = 1'b1;
                    end
                end
            end
            if (found) gap_d = '0;
        end
    end

    // game state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // datapath, free-running LFSR and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            t_q     <= '0;
            v_q     <= '0;
            score_q <= '0;
            gap_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            run_q   <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            t_q     <= t_d;
            v_q     <= v_d;
            score_q <= score_d;
            gap_q   <= gap_d;
            lfsr_q  <= {lfsr_q[14:0], lfsr_fb};
            run_q   <= (state_d == RUN);
            over_q  <= (state_d == OVER);
        end
    end

    assign bus.obs_x     = x_q;
    assign bus.obs_type  = t_q;
    assign bus.obs_valid = v_q;
    assign bus.score     = score_q;
    assign bus.running   = run_q;
    assign bus.game_over = over_q;
endmodule

// File: tb/tb_obstacle_manager.sv
// Bench for obstacle_manager: vector table plus random play,
// checked every cycle against a queued reference-model snapshot.
module tb_obstacle_manager;
    localparam int NS = 4;
    localparam int XW = 10;
    localparam int SW = 640;
    localparam int MG = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    obstacle_if #(.N_SLOTS(NS), .X_W(XW)) bus ();

    obstacle_manager #(
        .N_SLOTS(NS), .X_W(XW), .SCREEN_W(SW),
        .MIN_GAP(MG), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NS*XW-1:0] x;
        logic [NS-1:0]    t;
        logic [NS-1:0]    v;
        logic [15:0]      sc;
        logic             run;
        logic             over;
    } snap_t;

    typedef struct {
        int         n;
        logic       st;
        logic       ha;
        logic       tk;
        logic [3:0] sp;
        logic       co;
        logic       er;
        logic       eo;
    } vec_t;

    snap_t q[$];
    int n_total = 0;
    int n_pass  = 0;

    int          m_st;
    int          m_x[NS];
    bit          m_v[NS];
    bit          m_t[NS];
    int          m_sc;
    int          m_gap;
    logic [15:0] m_lfsr;

    task automatic model_reset();
        m_st = 0;
        m_sc = 0;
        m_gap = 0;
        m_lfsr = SEED;
        for (int k = 0; k < NS; k++) begin
            m_x[k] = 0; m_v[k] = 0; m_t[k] = 0;
        end
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.x = '0; s.t = '0; s.v = '0;
        for (int k = 0; k < NS; k++) begin
            s.x[k*XW +: XW] = XW'(m_x[k]);
            s.t[k] = m_t[k];
            s.v[k] = m_v[k];
        end
        s.sc = 16'(m_sc);
        s.run = (m_st == 1);
        s.over = (m_st == 2);
        return s;
    endfunction

    task automatic model_step(input logic st, input logic ha,
                              input logic tk, input int sp,
                              input logic co);
        int fr;
        int thr;
        bit fnd;
        logic fb;
        if (m_st != 1) begin
            if (st) begin
                m_st = 1; m_sc = 0; m_gap = 0;
                for (int k = 0; k < NS; k++) begin
                    m_x[k] = 0; m_v[k] = 0; m_t[k] = 0;
                end
            end
        end else if (co) begin
            m_st = 2;
        end else if (tk && !ha) begin
            fr = 0;
            for (int k = 0; k < NS; k++) begin
                if (m_v[k]) begin
                    if (m_x[k] < sp) begin
                        m_v[k] = 0; m_x[k] = 0; fr++;
                    end else begin
                        m_x[k] = m_x[k] - sp;
                    end
                end
            end
            m_sc = m_sc + fr;
            if (m_sc > 65535) m_sc = 65535;
            m_gap = m_gap + sp;
            if (m_gap > 2047) m_gap = 2047;
            thr = MG + 4 * int'(m_lfsr[5:0]);
            fnd = 0;
            if (m_gap >= thr) begin
                for (int k = 0; k < NS; k++) begin
                    if (!fnd && !m_v[k]) begin
                        m_x[k] = SW - 1; m_v[k] = 1;
                        m_t[k] = m_lfsr[0]; fnd = 1;
                    end
                end
            end
            if (fnd) m_gap = 0;
        end
        fb = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
        m_lfsr = {m_lfsr[14:0], fb};
    endtask

    task automatic compare(input string nm, input snap_t e);
        snap_t a;
        a.x = bus.obs_x; a.t = bus.obs_type; a.v = bus.obs_valid;
        a.sc = bus.score; a.run = bus.running; a.over = bus.game_over;
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL %s t=%0t got x=%h t=%b v=%b sc=%0d run=%b over=%b want x=%h t=%b v=%b sc=%0d run=%b over=%b",
            nm, $time, a.x, a.t, a.v, a.sc, a.run, a.over,
            e.x, e.t, e.v, e.sc, e.run, e.over);
    endtask

    // call at a negedge; returns at the following negedge
    task automatic drive_cycle(input logic st, input logic ha,
                               input logic tk, input logic [3:0] sp,
                               input logic co);
        bus.start = st; bus.halt = ha; bus.frame_tick = tk;
        bus.speed = sp; bus.collision = co;
        model_step(st, ha, tk, int'(sp), co);
        q.push_back(model_snap());
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            n_total++;
            $display("FAIL scoreboard_empty t=%0t", $time);
        end else begin
            compare("cycle", q.pop_front());
        end
        @(negedge clk);
    endtask

    vec_t vt[13];
    snap_t zero_s;

    initial begin
        vt[0]  = '{1,   1, 0, 0, 4'd0,  0, 1, 0};
        vt[1]  = '{1,   0, 0, 1, 4'd4,  0, 1, 0};
        vt[2]  = '{200, 0, 0, 1, 4'd8,  0, 1, 0};
        vt[3]  = '{10,  0, 1, 1, 4'd8,  0, 1, 0};
        vt[4]  = '{100, 0, 0, 1, 4'd15, 0, 1, 0};
        vt[5]  = '{30,  0, 0, 1, 4'd0,  0, 1, 0};
        vt[6]  = '{1,   0, 0, 1, 4'd8,  1, 0, 1};
        vt[7]  = '{5,   0, 0, 1, 4'd8,  0, 0, 1};
        vt[8]  = '{1,   0, 0, 1, 4'd8,  1, 0, 1};
        vt[9]  = '{1,   1, 0, 0, 4'd0,  0, 1, 0};
        vt[10] = '{150, 0, 0, 1, 4'd13, 0, 1, 0};
        vt[11] = '{1,   1, 0, 1, 4'd5,  0, 1, 0};
        vt[12] = '{200, 0, 0, 1, 4'd11, 0, 1, 0};

        zero_s = '{'0, '0, '0, 16'd0, 1'b0, 1'b0};
        bus.start = 0; bus.halt = 0; bus.frame_tick = 0;
        bus.speed = 0; bus.collision = 0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        compare("reset_state", zero_s);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            for (int c = 0; c < vt[i].n; c++) begin
                drive_cycle(vt[i].st, vt[i].ha, vt[i].tk,
                            vt[i].sp, vt[i].co);
            end
            n_total++;
            if (bus.running === vt[i].er && bus.game_over === vt[i].eo)
                n_pass++;
            else $display("FAIL vec%0d_flags got run=%b over=%b want run=%b over=%b",
                i, bus.running, bus.game_over, vt[i].er, vt[i].eo);
        end

        for (int c = 0; c < 3000; c++) begin
            drive_cycle(($urandom % 60) == 0, ($urandom % 8) == 0,
                        ($urandom % 3) != 0, 4'($urandom % 16),
                        ($urandom % 400) == 0);
        end

        drive_cycle(1, 0, 0, 4'd0, 0);
        for (int c = 0; c < 120; c++) drive_cycle(0, 0, 1, 4'd14, 0);

        #2;
        rst_n = 1'b0;
        #1;
        compare("midgame_reset", zero_s);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(0, 0, 1, 4'd9, 0);
        drive_cycle(1, 0, 0, 4'd0, 0);
        for (int c = 0; c < 300; c++) drive_cycle(0, 0, 1, 4'd12, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
